// File: rtl/card_plotter_if.sv
// Write-port bundle between the game controller (master) and card_plotter (slave).
interface card_plotter_if;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] fill_colour;
  logic [2:0] border_colour;
  logic       erase;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (
    output start, x_in, y_in, fill_colour, border_colour, erase,
    input  busy, done, x, y, colour, plot
  );

  modport slave (
    input  start, x_in, y_in, fill_colour, border_colour, erase,
    output busy, done, x, y, colour, plot
  );
endinterface

// File: rtl/card_plotter.sv
// Card plotter: streams one pixel per clock over a CARD_W x CARD_H rectangle to the
// vga_adapter write port, border in one colour, interior in another, with screen clipping.
module card_plotter #(
  parameter int unsigned CARD_W = 16,
  parameter int unsigned CARD_H = 24,
  parameter int unsigned X_MAX  = 160,
  parameter int unsigned Y_MAX  = 120
) (
  input logic            clk_i,
  input logic            rst_i,
  card_plotter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  state_e     state_q;
  logic [7:0] ox_q;
  logic [6:0] oy_q;
  logic [2:0] fill_q;
  logic [2:0] border_q;
  logic       erase_q;
  logic [5:0] cx_q;
  logic [5:0] cy_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q;
  logic       busy_q;
  logic       done_q;

  logic [8:0] xs;
  logic [7:0] ys;
  logic       cx_last;
  logic       cy_last;
  logic       on_border;
  logic       in_range;
  logic [2:0] pix_colour;

  // Address, border and clip decode for the pixel at (cx_q, cy_q).
  always_comb begin
    xs         = {1'b0, ox_q} + {3'b000, cx_q};
    ys         = {1'b0, oy_q} + {2'b00, cy_q};
    cx_last    = (cx_q == 6'(CARD_W - 1));
    cy_last    = (cy_q == 6'(CARD_H - 1));
    on_border  = (cx_q == 6'd0) || cx_last || (cy_q == 6'd0) || cy_last;
    in_range   = (xs < 9'(X_MAX)) && (ys < 8'(Y_MAX));
    pix_colour = erase_q ? 3'b000 : (on_border ? border_q : fill_q);
  end

  // Control FSM with registered pixel outputs; counters advance even when clipped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      ox_q     <= '0;
      oy_q     <= '0;
      fill_q   <= '0;
      border_q <= '0;
      erase_q  <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            ox_q     <= bus.x_in;
            oy_q     <= bus.y_in;
            fill_q   <= bus.fill_colour;
            border_q <= bus.border_colour;
            erase_q  <= bus.erase;
            cx_q     <= '0;
            cy_q     <= '0;
            busy_q   <= 1'b1;
            state_q  <= StDraw;
          end
        end
        StDraw: begin
          x_q      <= xs[7:0];
          y_q      <= ys[6:0];
          colour_q <= pix_colour;
          plot_q   <= in_range;
          if (cx_last && cy_last) begin
            state_q <= StDone;
          end else if (cx_last) begin
            cx_q <= '0;
            cy_q <= cy_q + 6'd1;
          end else begin
            cx_q <= cx_q + 6'd1;
          end
        end
        StDone: begin
          // busy drops as done rises so busy spans exactly CARD_W*CARD_H+1 cycles.
          plot_q  <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
